mul_sched: RTL and testbench
============================

# mul_sched

Round-robin scheduler and sequencer that shares one repeated-addition multiplier datapath between two requesters. It sits between the requesters and the datapath: A register (PIPO), P accumulator with clear, B down-counter loaded with din−1, adder, and zero comparator. It grants one requester at a time and drives the operand bus and the datapath control strobes. It returns the product with a one-cycle done pulse to the granted requester.

## Interface
- WIDTH, 16, operand/product width (bus, a*, b*, p_in, result)
- clk  input  1  clock, all state updates on posedge
- rst_n  input  1  asynchronous, active-low reset
- req0, req1  input  1 each  request level; operands must be held stable while high
- a0, b0, a1, b1  input  WIDTH each  multiplicand / multiplier of each requester
- gnt  output  2  one-hot grant, held for the whole operation
- done0, done1  output  1 each  one-cycle completion pulse
- result  output  WIDTH  equals p_in; valid only while a done is high
- bus  output  WIDTH  operand bus to datapath (A and B data inputs)
- lda, ldb, ldp, clrp, decb  output  1 each  datapath strobes (load A, load B=bus−1, P<=P+A, clear P, decrement B)
- eqz  input  1  datapath B==0, combinational
- p_in  input  WIDTH  datapath P register

## Operation
- States: IDLE, LDA, LDB, ADD, DONE.
- IDLE:
  - All strobes are 0 and gnt = 00.
  - If any req is high, pick a winner and go to LDA.
- Arbitration:
  - If only one requester is asking, it wins.
  - If both are asking, the requester not served last wins. A last-served pointer is updated on entry to DONE.
  - The pointer resets to 1, so requester 0 wins the first tie.
- LDA: bus = a of winner, lda = 1; go to LDB.
- LDB: bus = b of winner, ldb = 1, clrp = 1.
  - Go to ADD, or to DONE when zero skip fires (see Configuration).
- ADD: ldp = 1, decb = !eqz.
  - If eqz, this is the last add; go to DONE. Otherwise stay in ADD.
  - Exactly b ADD cycles are executed, since B enters ADD holding b−1.
- DONE: the done of the winner is 1 and gnt is still held; next state is IDLE.
- The product is modulo 2^WIDTH; no overflow indication.
- bus = 0 outside LDA/LDB.
- Requesters must deassert req at the edge on which they see done; IDLE samples req again on the following edge.
- A req dropped mid-operation is ignored; the operation completes and done still pulses.
- Changes to a non-granted requester's req or operands have no effect until IDLE.

## Timing
- Reset (async, any state): state = IDLE, pointer = 1.
  - gnt = 00, all strobes 0, done0 = done1 = 0, bus = 0.
  - Reset mid-operation abandons it with no done pulse.
- Let edge 0 be the edge at which IDLE samples req:
  - edge 0 → LDA
  - edge 1 → LDB
  - edge 2 → ADD (B = b−1, P = 0)
  - edges 3 … b+2 → ADD cycles; the last of these moves to DONE
  - done is high for the cycle after edge b+2
- Latency to done: b+3 cycles; occupancy b+4 cycles including DONE.
- Back-to-back: the earliest next grant is the edge after the DONE cycle.
- Strobes are registered state decodes (Moore), except decb, which also depends on eqz.

## Configuration
- MUL_SCHED_ZERO_SKIP_EN defined:
  - In LDB, if the winner's a == 0 or b == 0, go straight to DONE; clrp in LDB makes P = 0.
  - done follows 2 cycles after edge 0.
- Undefined:
  - No skip. a == 0 runs b adds of 0.
  - b == 0 loads B = all-ones and runs 2^WIDTH ADD cycles; P wraps to 0, so result is 0.

## Test plan
- req0 with a0=17, b0=5: lda at the cycle after edge 0, ldb+clrp next, 5 ADD cycles; done0 after edge 7, result = 85, gnt = 01 throughout.
- req0 and req1 rise together after reset (3×4 and 6×2): requester 0 is served first (result 12), then requester 1 at the edge after DONE (result 12). A second simultaneous pair is served in order 1 then 0.
- b1 = 1, a1 = 0xFFFF: exactly one ADD cycle with decb = 0; done1 after edge 3, result = 0xFFFF.
- b0 = 0:
  - with MUL_SCHED_ZERO_SKIP_EN, done0 after edge 2 with result 0;
  - without it, done0 after 65539 edges with result 0.
- rst_n pulsed low during ADD of a 9×7 operation: all outputs 0 immediately, no done; after release, the same request completes with result 63.
- req1 held after done1 while req0 idle: requester 1 is granted again one cycle after DONE; req0 raised during that operation is served next.

Source files
------------

// File: rtl/mul_sched.sv
// Round-robin scheduler/sequencer sharing one repeated-addition multiplier between two requesters.
// Optional zero-operand early exit: define MUL_SCHED_ZERO_SKIP_EN.
module mul_sched #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       gnt,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] bus,
    output logic             lda,
    output logic             ldb,
    output logic             ldp,
    output logic             clrp,
    output logic             decb,
    input  logic             eqz,
    input  logic [WIDTH-1:0] p_in
);

    // state | meaning
    // IDLE  | no grant, waiting for a request
    // LDA   | winner's a on bus, load A
    // LDB   | winner's b on bus, load B = b-1, clear P
    // ADD   | P <= P + A, decrement B until B == 0
    // DONE  | done pulse to winner, grant still held
    typedef enum logic [2:0] {IDLE, LDA, LDB, ADD, DONE} state_t;

    state_t           state_q, state_d;
    logic             win_q, win_d;
    logic             ptr_q, ptr_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic [WIDTH-1:0] bus_q, bus_d;
    logic             lda_q, lda_d;
    logic             ldb_q, ldb_d;
    logic             ldp_q, ldp_d;
    logic             clrp_q, clrp_d;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = LDA;
                    // on a tie, the requester not served last wins
                    win_d   = (req0 && req1) ? ~ptr_q : req1;
                end
            end
            LDA: state_d = LDB;
            LDB: begin
`ifdef MUL_SCHED_ZERO_SKIP_EN
                if ((win_q ? a1 : a0) == '0 || (win_q ? b1 : b0) == '0)
                    state_d = DONE;
                else
                    state_d = ADD;
`else
                state_d = ADD;
`endif
            end
            ADD:  if (eqz) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == DONE && state_q != DONE)
            ptr_d = win_d;

        // outputs are decoded from the next state so they register as Moore outputs
        gnt_d   = (state_d == IDLE) ? 2'b00 : (win_d ? 2'b10 : 2'b01);
        bus_d   = '0;
        if (state_d == LDA) bus_d = win_d ? a1 : a0;
        if (state_d == LDB) bus_d = win_d ? b1 : b0;
        lda_d   = (state_d == LDA);
        ldb_d   = (state_d == LDB);
        clrp_d  = (state_d == LDB);
        ldp_d   = (state_d == ADD);
        done0_d = (state_d == DONE) && !win_d;
        done1_d = (state_d == DONE) && win_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            ptr_q   <= 1'b1;
            gnt_q   <= 2'b00;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            bus_q   <= '0;
            lda_q   <= 1'b0;
            ldb_q   <= 1'b0;
            ldp_q   <= 1'b0;
            clrp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            bus_q   <= bus_d;
            lda_q   <= lda_d;
            ldb_q   <= ldb_d;
            ldp_q   <= ldp_d;
            clrp_q  <= clrp_d;
        end
    end

    assign gnt    = gnt_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign bus    = bus_q;
    assign lda    = lda_q;
    assign ldb    = ldb_q;
    assign ldp    = ldp_q;
    assign clrp   = clrp_q;
    // B must stop at zero on the final add, so decb follows eqz combinationally
    assign decb   = ldp_q & ~eqz;
    assign result = p_in;

endmodule

// File: tb/tb_mul_sched.sv
// Testbench for mul_sched: behavioral datapath model plus a scoreboard of expected products.
module tb_mul_sched;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]   gnt;
    logic         done0, done1;
    logic [W-1:0] result, bus;
    logic         lda, ldb, ldp, clrp, decb;
    logic         eqz;
    logic [W-1:0] p_in;

    logic [W-1:0] dp_a = '0, dp_b = '0, dp_p = '0;

    mul_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt(gnt), .done0(done0), .done1(done1),
        .result(result), .bus(bus),
        .lda(lda), .ldb(ldb), .ldp(ldp), .clrp(clrp), .decb(decb),
        .eqz(eqz), .p_in(p_in)
    );

    always #5 clk = ~clk;

    // datapath: A register, B down-counter loaded with bus-1, P accumulator
    always @(posedge clk) begin
        if (lda) dp_a <= bus;
        if (ldb) dp_b <= bus - 16'd1;
        else if (decb) dp_b <= dp_b - 16'd1;
        if (clrp) dp_p <= '0;
        else if (ldp) dp_p <= dp_p + dp_a;
    end
    assign eqz  = (dp_b == '0);
    assign p_in = dp_p;

    typedef struct {
        logic [1:0]   who;
        logic [W-1:0] prod;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   last_done_cyc = 0;
    bit   hold1 = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // done monitor: pops the scoreboard, then drops the finished requester's req
    initial forever begin
        @(negedge clk);
        if (done0 || done1) begin
            exp_t e;
            done_cnt = done_cnt + 1;
            last_done_cyc = cyc;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: done=%b result=%h, no operation pending", {done1, done0}, result);
            end else begin
                e = sb.pop_front();
                if ({done1, done0} !== e.who) begin
                    bad++;
                    $display("FAIL done_owner: got %b want %b", {done1, done0}, e.who);
                end
                total++;
                if (result !== e.prod) begin
                    bad++;
                    $display("FAIL result: got %h want %h", result, e.prod);
                end
                total++;
                if (gnt !== e.who) begin
                    bad++;
                    $display("FAIL gnt_at_done: got %b want %b", gnt, e.who);
                end
            end
            if (done0) req0 = 1'b0;
            if (done1 && !hold1) req1 = 1'b0;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] who, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.who  = who;
        e.prod = a * b;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        total++;
        if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        total++;
        if ({lda, ldb, ldp, clrp, decb} !== 5'b0) begin
            bad++; $display("FAIL reset_strobes: got %b want 00000", {lda, ldb, ldp, clrp, decb});
        end
        total++;
        if ({done1, done0} !== 2'b00) begin bad++; $display("FAIL reset_done: got %b want 00", {done1, done0}); end
        total++;
        if (bus !== '0) begin bad++; $display("FAIL reset_bus: got %h want 0000", bus); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_tie();
        int base, e0, d;
        base = done_cnt;
        a0 = 16'd3; b0 = 16'd4; a1 = 16'd6; b1 = 16'd2;
        push(2'b01, a0, b0);
        push(2'b10, a1, b1);
        req0 = 1'b1; req1 = 1'b1;
        e0 = cyc + 1;
        step();
        total++;
        if (gnt !== 2'b01) begin bad++; $display("FAIL tie_first_gnt: got %b want 01", gnt); end
        for (int i = 0; i < 50 && done_cnt < base + 1; i++) step();
        total++;
        if (done_cnt < base + 1) begin bad++; $display("FAIL tie_timeout1: dones %0d want %0d", done_cnt - base, 1); end
        total++;
        if (last_done_cyc - e0 !== 6) begin bad++; $display("FAIL tie_latency0: got %0d want 6", last_done_cyc - e0); end
        d = last_done_cyc;
        for (int i = 0; i < 50 && done_cnt < base + 2; i++) step();
        total++;
        if (done_cnt < base + 2) begin bad++; $display("FAIL tie_timeout2: dones %0d want %0d", done_cnt - base, 2); end
        total++;
        if (last_done_cyc - d !== 6) begin bad++; $display("FAIL tie_b2b_gap: got %0d want 6", last_done_cyc - d); end
        step();
    endtask

    task automatic test_single();
        int e0, adds;
        a0 = 16'd17; b0 = 16'd5;
        push(2'b01, a0, b0);
        req0 = 1'b1;
        e0 = cyc + 1;
        step();
        total++;
        if ({lda, gnt, bus} !== {1'b1, 2'b01, 16'd17}) begin
            bad++; $display("FAIL single_lda: lda=%b gnt=%b bus=%h want 1 01 0011", lda, gnt, bus);
        end
        step();
        total++;
        if ({ldb, clrp, lda, bus} !== {1'b1, 1'b1, 1'b0, 16'd5}) begin
            bad++; $display("FAIL single_ldb: ldb=%b clrp=%b lda=%b bus=%h want 1 1 0 0005", ldb, clrp, lda, bus);
        end
        step();
        adds = 0;
        while (ldp === 1'b1 && adds < 100) begin
            adds++;
            step();
        end
        total++;
        if (adds !== 5) begin bad++; $display("FAIL single_adds: got %0d want 5", adds); end
        total++;
        if (done0 !== 1'b1) begin bad++; $display("FAIL single_done0: got %b want 1", done0); end
        total++;
        if (cyc - e0 !== 7) begin bad++; $display("FAIL single_latency: got %0d want 7", cyc - e0); end
        step();
        total++;
        if ({gnt, bus} !== 18'b0) begin bad++; $display("FAIL single_idle: gnt=%b bus=%h want 00 0000", gnt, bus); end
    endtask

    task automatic test_tie_rev();
        int base;
        base = done_cnt;
        a0 = 16'd7; b0 = 16'd3; a1 = 16'd11; b1 = 16'd2;
        push(2'b10, a1, b1);
        push(2'b01, a0, b0);
        req0 = 1'b1; req1 = 1'b1;
        step();
        total++;
        if (gnt !== 2'b10) begin bad++; $display("FAIL tie_rev_first_gnt: got %b want 10", gnt); end
        for (int i = 0; i < 60 && done_cnt < base + 2; i++) step();
        total++;
        if (done_cnt < base + 2) begin bad++; $display("FAIL tie_rev_timeout: dones %0d want 2", done_cnt - base); end
        step();
    endtask

    task automatic test_max_a();
        int e0;
        a1 = 16'hFFFF; b1 = 16'd1;
        push(2'b10, a1, b1);
        req1 = 1'b1;
        e0 = cyc + 1;
        step();
        step();
        step();
        total++;
        if ({ldp, decb} !== 2'b10) begin bad++; $display("FAIL maxa_add: ldp=%b decb=%b want 1 0", ldp, decb); end
        step();
        total++;
        if ({done1, ldp} !== 2'b10) begin bad++; $display("FAIL maxa_done: done1=%b ldp=%b want 1 0", done1, ldp); end
        total++;
        if (cyc - e0 !== 3) begin bad++; $display("FAIL maxa_latency: got %0d want 3", cyc - e0); end
        step();
    endtask

    task automatic test_reset_mid();
        int base;
        base = done_cnt;
        a0 = 16'd9; b0 = 16'd7;
        push(2'b01, a0, b0);
        req0 = 1'b1;
        step(); step(); step(); step();
        total++;
        if (ldp !== 1'b1) begin bad++; $display("FAIL rmid_in_add: ldp=%b want 1", ldp); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({gnt, done1, done0, bus} !== 20'b0) begin
            bad++; $display("FAIL rmid_outputs: gnt=%b done=%b bus=%h want all 0", gnt, {done1, done0}, bus);
        end
        total++;
        if ({lda, ldb, ldp, clrp, decb} !== 5'b0) begin
            bad++; $display("FAIL rmid_strobes: got %b want 00000", {lda, ldb, ldp, clrp, decb});
        end
        step(); step();
        total++;
        if (done_cnt !== base) begin bad++; $display("FAIL rmid_no_done: dones %0d want 0", done_cnt - base); end
        rst_n = 1'b1;
        for (int i = 0; i < 50 && done_cnt < base + 1; i++) step();
        total++;
        if (done_cnt < base + 1) begin bad++; $display("FAIL rmid_timeout: dones %0d want 1", done_cnt - base); end
        step();
    endtask

    task automatic test_hold1();
        int base;
        base = done_cnt;
        hold1 = 1'b1;
        a1 = 16'd2; b1 = 16'd3;
        push(2'b10, a1, b1);
        push(2'b10, a1, b1);
        req1 = 1'b1;
        for (int i = 0; i < 50 && done_cnt < base + 1; i++) step();
        total++;
        if (done_cnt < base + 1) begin bad++; $display("FAIL hold_timeout1: dones %0d want 1", done_cnt - base); end
        step();
        total++;
        if (gnt !== 2'b00) begin bad++; $display("FAIL hold_idle_gnt: got %b want 00", gnt); end
        step();
        total++;
        if ({gnt, lda} !== 3'b101) begin bad++; $display("FAIL hold_regrant: gnt=%b lda=%b want 10 1", gnt, lda); end
        a0 = 16'd5; b0 = 16'd5;
        push(2'b01, a0, b0);
        req0 = 1'b1;
        hold1 = 1'b0;
        for (int i = 0; i < 60 && done_cnt < base + 3; i++) step();
        total++;
        if (done_cnt < base + 3) begin bad++; $display("FAIL hold_timeout3: dones %0d want 3", done_cnt - base); end
        step();
    endtask

    task automatic test_zero_b();
        int base, e0, want;
`ifdef MUL_SCHED_ZERO_SKIP_EN
        want = 2;
`else
        want = 65538;
`endif
        base = done_cnt;
        a0 = 16'd5; b0 = 16'd0;
        push(2'b01, a0, b0);
        req0 = 1'b1;
        e0 = cyc + 1;
        for (int i = 0; i < 70000 && done_cnt < base + 1; i++) step();
        total++;
        if (done_cnt < base + 1) begin bad++; $display("FAIL zero_b_timeout: dones %0d want 1", done_cnt - base); end
        total++;
        if (last_done_cyc - e0 !== want) begin
            bad++; $display("FAIL zero_b_latency: got %0d want %0d", last_done_cyc - e0, want);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_tie_rev();
        test_max_a();
        test_reset_mid();
        test_hold1();
        test_zero_b();
        total++;
        if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
